// File: rtl/load_w_packer.sv
// Weight-buffer load packer: gathers BEATS narrow beats from the DDR load
// stream into one full-width buffer line and writes each finished line
// through the buffer's load write port. One command loads a run of lines
// starting at a base address; a single-cycle done pulse ends the run.
module load_w_packer #(
    parameter int BUFFER_ADDR_WIDTH = 13,
    parameter int BUFFER_DATA_WIDTH = 8192,
    parameter int IN_DATA_WIDTH     = 512,
    parameter int LINE_NUM_WIDTH    = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_buf_addr,
    input  logic [LINE_NUM_WIDTH-1:0]    cmd_line_num,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_DATA_WIDTH-1:0]     in_data,
    output logic                         load_write_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
    output logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
    output logic                         busy,
    output logic                         done
);

    // BUFFER_DATA_WIDTH must be an integer multiple (>= 2) of IN_DATA_WIDTH.
    localparam int BEATS  = BUFFER_DATA_WIDTH / IN_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                         state_reg, state_next;
    logic [BUFFER_ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [LINE_NUM_WIDTH-1:0]      lines_reg, lines_next;
    logic [LINE_NUM_WIDTH-1:0]      line_cnt_reg, line_cnt_next;
    logic [BEAT_W-1:0]              beat_cnt_reg, beat_cnt_next;
    logic                           wr_valid_reg, wr_valid_next;
    logic [BUFFER_ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
    logic [BUFFER_DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;

    // Only the first BEATS-1 beats need storage: the final beat of a line
    // goes straight from in_data into the outgoing write register.
    logic [IN_DATA_WIDTH-1:0]       pack_reg [BEATS-1];
    logic [BUFFER_DATA_WIDTH-1:0]   line_full;
    logic [LINE_NUM_WIDTH-1:0]      line_inc;
    logic                           accept;
    logic                           last_beat;

    assign accept    = in_valid && (state_reg == ST_RUN);
    assign last_beat = (beat_cnt_reg == BEAT_W'(BEATS - 1));
    assign line_inc  = line_cnt_reg + LINE_NUM_WIDTH'(1);

    // Per-slice beat capture and assembly of the completed line.
    generate
        for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_pack
            // Store the accepted beat into the slice selected by beat_cnt.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pack_reg[gi] <= '0;
                end else if (accept && (beat_cnt_reg == BEAT_W'(gi))) begin
                    pack_reg[gi] <= in_data;
                end
            end
            assign line_full[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = pack_reg[gi];
        end
    endgenerate
    assign line_full[BUFFER_DATA_WIDTH-1 -: IN_DATA_WIDTH] = in_data;

    // State, command context, counters and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            base_reg     <= '0;
            lines_reg    <= '0;
            line_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            lines_reg    <= lines_next;
            line_cnt_reg <= line_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            wr_valid_reg <= wr_valid_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    // Next-state logic; the write port defaults to zero so address and data
    // read as 0 on every cycle without a strobe.
    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        lines_next    = lines_reg;
        line_cnt_next = line_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        wr_valid_next = 1'b0;
        wr_addr_next  = '0;
        wr_data_next  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    base_next     = cmd_buf_addr;
                    lines_next    = cmd_line_num;
                    line_cnt_next = '0;
                    beat_cnt_next = '0;
                    state_next    = (cmd_line_num == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        beat_cnt_next = '0;
                        line_cnt_next = line_inc;
                        wr_valid_next = 1'b1;
                        // Address arithmetic wraps modulo the buffer depth.
                        wr_addr_next  = base_reg + BUFFER_ADDR_WIDTH'(line_cnt_reg);
                        wr_data_next  = line_full;
                        if (line_inc == lines_reg) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready             = (state_reg == ST_IDLE);
    assign in_ready              = (state_reg == ST_RUN);
    assign busy                  = (state_reg != ST_IDLE);
    assign done                  = (state_reg == ST_DONE);
    assign load_write_addr_valid = wr_valid_reg;
    assign load_write_addr       = wr_addr_reg;
    assign load_write_data       = wr_data_reg;

endmodule
